// File: rtl/lsu_pkg.sv
// Shared types and helpers for the RV32I load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width code is legal for the direction (stores have no unsigned forms).
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = ~we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halfwords need even addresses, words need word-aligned addresses.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Byte enables of a store placed on its byte lane.
    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] lo);
        logic [3:0] m;
        case (f3)
            F3_B:    m = 4'b0001 << lo;
            F3_H:    m = 4'b0011 << lo;
            F3_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shift the addressed byte lane down and extend.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted_s;

    // Select the lane and apply sign or zero extension by width code.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted_s[7]}}, shifted_s[7:0]};
            F3_H:    result = {{16{shifted_s[15]}}, shifted_s[15:0]};
            F3_W:    result = shifted_s;
            F3_BU:   result = {24'd0, shifted_s[7:0]};
            F3_HU:   result = {16'd0, shifted_s[15:0]};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding memory access, registered outputs.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    lsu_state_e  state_q, state_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        ready_q, ready_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_bmask_q, mem_bmask_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] load_res_s;
    logic        bad_req_s;

    lsu_load_align u_align (
        .rdata   (i_mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .result  (load_res_s)
    );

    // Next-state and next-output decode; outputs idle at zero outside their phase.
    always_comb begin
        state_d     = state_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wdata_d = 32'd0;
        mem_bmask_d = 4'b0000;
        rsp_valid_d = 1'b0;
        rdata_d     = 32'd0;
        err_d       = 1'b0;
        bad_req_s   = ~f3_legal(i_we, i_funct3) | misaligned(i_funct3, i_addr[1:0]);
        case (state_q)
            IDLE: begin
                if (i_req_valid && ready_q) begin
                    addr_lo_d = i_addr[1:0];
                    funct3_d  = i_funct3;
                    if (bad_req_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = i_we;
                        mem_addr_d  = {i_addr[31:2], 2'b00};
                        mem_wdata_d = i_we ? (i_wdata << {i_addr[1:0], 3'b000}) : 32'd0;
                        mem_bmask_d = i_we ? store_mask(i_funct3, i_addr[1:0]) : 4'b0000;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (i_mem_ack) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rdata_d     = mem_we_q ? 32'd0 : load_res_s;
                end else begin
                    mem_req_d   = mem_req_q;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_bmask_d = mem_bmask_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and registered output flops; reset clears everything immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= 2'b00;
            funct3_q    <= 3'b000;
            ready_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_bmask_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            ready_q     <= ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign o_req_ready = ready_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_bmask = mem_bmask_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rdata     = rdata_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table plus random model.
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_err;

    int nvec  = 0;
    int nfail = 0;

    always #5 i_clk = ~i_clk;

    load_store_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rdata     (o_rdata),
        .o_err       (o_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
        logic        exp_err;
        logic [3:0]  exp_bmask;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [3:0]  bmask;
        logic [31:0] mwdata;
        logic [31:0] rdata;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model written from the RV32I access rules with plain arithmetic.
    function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        int size = 1;
        bit sgn = 1'b0;
        bit legal = 1'b1;
        int lo = int'(addr[1:0]);
        longint unsigned v;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        e.err = 1'b0; e.bmask = 4'd0; e.mwdata = 32'd0; e.rdata = 32'd0;
        if (!legal || (lo % size) != 0) begin
            e.err = 1'b1;
        end else if (we) begin
            v = ((64'd1 << size) - 64'd1) << lo;
            e.bmask  = v[3:0];
            v = 64'(wdata) << (8 * lo);
            e.mwdata = v[31:0];
        end else begin
            v = (64'(rdata) >> (8 * lo)) & ((64'd1 << (8 * size)) - 64'd1);
            if (sgn && v >= (64'd1 << (8 * size - 1)))
                v = v + (64'd1 << 32) - (64'd1 << (8 * size));
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    // One request from the IDLE negedge through its response cycle.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int delay,
                           input exp_t e);
        chk("ready_idle", 32'(o_req_ready), 32'd1);
        i_req_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        if (e.err) begin
            chk("err_memreq", 32'(o_mem_req), 32'd0);
        end else begin
            for (int k = 0; k <= delay; k++) begin
                chk("mem_req", 32'(o_mem_req), 32'd1);
                chk("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
                chk("mem_we", 32'(o_mem_we), 32'(we));
                chk("mem_bmask", 32'(o_mem_bmask), 32'(e.bmask));
                if (we) chk("mem_wdata", o_mem_wdata, e.mwdata);
                chk("rsp_early", 32'(o_rsp_valid), 32'd0);
                chk("ready_busy", 32'(o_req_ready), 32'd0);
                if (k == delay) begin
                    i_mem_ack = 1'b1; i_mem_rdata = rdata;
                end else begin
                    i_mem_ack = 1'b0; i_mem_rdata = $urandom;
                    i_req_valid = 1'($urandom); i_addr = $urandom; i_we = 1'($urandom);
                end
                @(negedge i_clk);
            end
            i_mem_ack = 1'b0; i_req_valid = 1'b0;
        end
        chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
        chk("rsp_err", 32'(o_err), 32'(e.err));
        chk("rsp_rdata", o_rdata, e.rdata);
        chk("rsp_memreq", 32'(o_mem_req), 32'd0);
        chk("rsp_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clk);
        chk("rsp_pulse", 32'(o_rsp_valid), 32'd0);
    endtask

    vec_t vecs[$];
    exp_t e;

    initial begin
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_wdata = 32'd0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;

        //                 we  f3    addr          wdata         rdata     dly err bmask  mwdata        rdata
        vecs.push_back('{1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        0, 1'b0, 4'h8, 32'hA5000000, 32'h0});
        vecs.push_back('{1'b0, 3'd0, 32'h102, 32'h0,        32'h12F45678, 0, 1'b0, 4'h0, 32'h0, 32'hFFFFFFF4});
        vecs.push_back('{1'b0, 3'd4, 32'h102, 32'h0,        32'h12F45678, 0, 1'b0, 4'h0, 32'h0, 32'h000000F4});
        vecs.push_back('{1'b0, 3'd5, 32'h102, 32'h0,        32'h12F45678, 0, 1'b0, 4'h0, 32'h0, 32'h000012F4});
        vecs.push_back('{1'b0, 3'd1, 32'h102, 32'h0,        32'h12F45678, 1, 1'b0, 4'h0, 32'h0, 32'h000012F4});
        vecs.push_back('{1'b0, 3'd1, 32'h101, 32'h0,        32'h12F45678, 0, 1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h200, 32'h0,        32'hCAFEF00D, 3, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D});
        vecs.push_back('{1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0,        2, 1'b0, 4'hC, 32'hABCD0000, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h202, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd6, 32'h100, 32'h0,        32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 3'd4, 32'h100, 32'h11,       32'h0,        0, 1'b1, 4'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h100, 32'h0,        32'h00008001, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF8001});
        vecs.push_back('{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 0, 1'b0, 4'h0, 32'h0, 32'h0000007F});
        vecs.push_back('{1'b1, 3'd2, 32'h104, 32'h01020304, 32'h0,        1, 1'b0, 4'hF, 32'h01020304, 32'h0});

        // Reset state, then ready only after the first edge past release.
        #1;
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_memreq", 32'(o_mem_req), 32'd0);
        chk("rst_rsp", 32'(o_rsp_valid), 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        foreach (vecs[i]) begin
            e.err = vecs[i].exp_err; e.bmask = vecs[i].exp_bmask;
            e.mwdata = vecs[i].exp_mwdata; e.rdata = vecs[i].exp_rdata;
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].delay, e);
        end

        // Reset in the middle of a load, followed by a late acknowledge.
        i_req_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'd2; i_addr = 32'h300;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("pre_rst_memreq", 32'(o_mem_req), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_memreq", 32'(o_mem_req), 32'd0);
        chk("mid_rst_addr", o_mem_addr, 32'd0);
        chk("mid_rst_ready", 32'(o_req_ready), 32'd0);
        chk("mid_rst_err", 32'(o_err), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h55AA55AA;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        chk("late_ack_rsp", 32'(o_rsp_valid), 32'd0);
        chk("post_rst_ready", 32'(o_req_ready), 32'd1);
        @(negedge i_clk);
        chk("late_ack_rsp2", 32'(o_rsp_valid), 32'd0);
        chk("late_ack_memreq", 32'(o_mem_req), 32'd0);

        // Randomized requests against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr, wd, rd;
            int          dly;
            we = 1'($urandom); f3 = 3'($urandom); addr = $urandom;
            wd = $urandom; rd = $urandom; dly = int'($urandom_range(0, 3));
            e = model(we, f3, addr, wd, rd);
            run_txn(we, f3, addr, wd, rd, dly, e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Block SHALL use one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 i_clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous active-low reset.
REQ-004 i_req_valid  input  1  execute stage presents a load/store request.
REQ-005 o_req_ready  output  1  high only in IDLE; request accepted when i_req_valid & o_req_ready.
REQ-006 i_we  input  1  1 = store, 0 = load.
REQ-007 i_funct3  input  3  RV32I width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008 i_addr  input  32  effective address; this is the ALU o_alu_data ADD result.
REQ-009 i_wdata  input  32  store data in rs2, LSB-justified.
REQ-010 o_mem_req  output  1  memory request, held high until acknowledged.
REQ-011 o_mem_we  output  1  memory write enable.
REQ-012 o_mem_addr  output  32  word address, i.e. {addr[31:2],2'b00}.
REQ-013 o_mem_wdata  output  32  store data shifted to its byte lane.
REQ-014 o_mem_bmask  output  4  byte enables; 4'b0000 for loads.
REQ-015 i_mem_ack  input  1  memory completes the access this cycle; i_mem_rdata is valid.
REQ-016 i_mem_rdata  input  32  read word.
REQ-017 o_rsp_valid  output  1  one-cycle response pulse.
REQ-018 o_rdata  output  32  aligned load result; 0 for stores and errors.
REQ-019 o_err  output  1  qualifies o_rsp_valid: misaligned access or illegal funct3.

Function
REQ-020 FSM states SHALL be IDLE, REQ and RESP.
REQ-021 On acceptance in IDLE, the block SHALL register addr[1:0], we, funct3 and wdata.
- Legal and aligned request -> REQ.
- Misaligned request (H with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (011, 110, 111; or 1xx on a store) -> RESP with o_err=1.
REQ-022 In REQ, o_mem_req SHALL be 1, and o_mem_addr/we/wdata/bmask SHALL stay stable until the cycle i_mem_ack=1.
- i_mem_ack=1 -> RESP.
- i_mem_ack is ignored in all other states.
REQ-023 Byte masks: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<addr[1:0]; SW = 4'b1111.
- o_mem_wdata SHALL be i_wdata<<(8*addr[1:0]).
REQ-024 Load data SHALL be captured on the ack edge and formatted as follows.
- Extract: i_mem_rdata>>(8*addr[1:0]).
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
REQ-025 In RESP, o_rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
- Error path: no memory transaction occurs and o_mem_req stays 0.
REQ-026 Minimum latency SHALL be: accept edge N, REQ cycle N+1 with same-cycle ack, RESP cycle N+2, ready again cycle N+3.
- Each cycle of ack delay adds one cycle.
REQ-027 i_req_valid outside IDLE SHALL be ignored, with no queuing.
REQ-028 Outputs SHALL be glitch-free registered decodes of state and captured fields; no output SHALL combinationally depend on i_req_valid.

Reset
REQ-029 Asserting i_rst_n=0 SHALL immediately force the following.
- State = IDLE.
- o_mem_req, o_mem_we, o_rsp_valid, o_err = 0.
- o_mem_bmask = 0; o_rdata, o_mem_addr, o_mem_wdata = 0.
- o_req_ready = 0 while in reset, 1 after release.
REQ-030 Reset during REQ SHALL abandon the transaction with no response pulse; a late i_mem_ack after release SHALL be ignored.

Structure
REQ-031 Shared package lsu_pkg SHALL hold the state enum (IDLE/REQ/RESP) and the funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
REQ-032 Load extraction/extension SHALL be one combinational sub-module, lsu_load_align (inputs: rdata, addr[1:0], funct3; output: 32-bit result).
REQ-033 Target implementation size is 150-300 lines of RTL.

Verification
REQ-034 SW addr 0x100, wdata 0xDEADBEEF, ack same cycle -> o_mem_addr 0x100, bmask 1111, mem_wdata 0xDEADBEEF, rsp_valid at N+2, err 0.
REQ-035 SB addr 0x103, wdata 0x000000A5 -> o_mem_addr 0x100, bmask 1000, mem_wdata 0xA5000000.
REQ-036 LB addr 0x102, rdata 0x12F45678 -> o_rdata 0xFFFFFFF4; LBU gives 0x000000F4; LHU addr 0x102 gives 0x000012F4.
REQ-037 LH addr 0x101 -> o_mem_req never 1, rsp_valid at N+1 cycle-after-accept with err 1 and o_rdata 0.
REQ-038 LW addr 0x200, ack delayed 3 cycles -> mem_req and addr stable for 4 cycles, rsp_valid one cycle after ack, i_req_valid pulses meanwhile ignored.
REQ-039 i_rst_n low during REQ, then ack after release -> all outputs 0 immediately, no rsp_valid, o_req_ready 1 after release.
